cache_rd_arbiter: RTL and testbench
===================================

# cache_rd_arbiter

Shares the single AXI read channel between the instruction cache and the data cache. Each cache presents a request on its own cache-side read port (`rd_req`/`rd_type`/`rd_addr`/`rd_rdy`, `ret_valid`/`ret_data`). The block arbitrates round-robin, issues one AXI AR burst, gathers the R beats into a 256-bit line buffer, and returns the buffer to the granted cache in a single `ret_valid` pulse. One transaction is outstanding at a time.

## Interface
- `ID_I`, 4'd0, AXI `arid` used for icache transactions
- `ID_D`, 4'd1, AXI `arid` used for dcache transactions
- `clk` in 1: clock, all state on rising edge
- `reset` in 1: asynchronous, active-high reset
- `i_rd_req` in 1: icache read request
- `i_rd_type` in 1: 1 = 8-word line, 0 = single word (uncached)
- `i_rd_addr` in 32: icache request address
- `i_rd_rdy` out 1: icache request accepted this cycle
- `i_ret_valid` out 1: one-cycle pulse, icache data returned
- `i_ret_data` out 256: returned line; a single word is returned in [31:0]
- `d_rd_req`, `d_rd_type`, `d_rd_addr`, `d_rd_rdy`, `d_ret_valid`, `d_ret_data`: same widths and meanings, dcache side
- `arid` out 4, `araddr` out 32, `arlen` out 8, `arsize` out 3, `arburst` out 2, `arvalid` out 1, `arready` in 1: AXI AR channel
- `rid` in 4, `rdata` in 32, `rresp` in 2, `rlast` in 1, `rvalid` in 1, `rready` out 1: AXI R channel

## Operation
- FSM states and transitions:
  - IDLE → AR on an accepted request.
  - AR → R on `arvalid && arready`.
  - R → RET on `rvalid && rlast`.
  - RET → IDLE unconditionally.
- IDLE arbitration:
  - The winner is chosen combinationally from `i_rd_req`/`d_rd_req`.
  - If only one requester is active, it wins.
  - If both are active, the requester not granted last wins. A 1-bit `last_grant` register is reset to icache, so dcache wins the first tie.
  - The winner's `*_rd_rdy` is 1 in IDLE only; the loser's `*_rd_rdy` stays 0.
- Acceptance (`rd_req && rd_rdy`):
  - Latch `grant`, `type` and `addr`.
  - Update `last_grant`.
  - Clear the line buffer to 0 and the beat counter to 0.
  - Go to AR.
- Requesters hold `rd_req`, `rd_type` and `rd_addr` stable until `rd_rdy`. Requests arriving outside IDLE wait; `rd_rdy` is 0 in AR, R and RET.
- AR outputs:
  - `arvalid`=1 with `araddr` = latched address, passed unmodified (caches align lines).
  - `arid` = `ID_I` or `ID_D` per grant.
  - `arlen` = type ? 8'd7 : 8'd0.
  - `arsize` = 3'b010.
  - `arburst` = 2'b01 (INCR).
  - AR fields are held stable until `arready`.
- R:
  - `rready`=1.
  - Each `rvalid` beat writes `rdata` into buffer word `cnt` (bits [32·cnt+31 : 32·cnt]), then `cnt` increments by 1 (3-bit, wraps mod 8).
  - `rid` and `rresp` are ignored.
- RET:
  - The granted cache's `*_ret_valid`=1 for exactly one cycle.
  - `*_ret_data` = buffer.
  - The other cache's `ret_valid` stays 0.
- Boundary behaviour:
  - `rlast` earlier than 8 beats on a line request: go to RET anyway; unwritten words read 0.
  - More than 8 beats without `rlast`: `cnt` wraps and overwrites from word 0. This is a slave protocol violation; no error is flagged.
  - `rvalid` outside R is ignored (`rready`=0).
  - Simultaneous `i_rd_req` and `d_rd_req` in IDLE: round-robin rule above, exactly one grant.
  - Reset asserted mid-transaction: immediate return to IDLE. The outstanding AXI burst is abandoned; system reset resets the slave too.

## Timing
- Reset values:
  - State = IDLE, `last_grant` = icache, buffer = 0, `cnt` = 0.
  - `arvalid`, `rready`, `i_ret_valid`, `d_ret_valid` = 0.
  - `araddr`, `arid`, `arlen` = 0; `*_ret_data` = 0.
  - `rd_rdy` is combinational, IDLE-gated.
- Request to AR latency: accept in cycle T0; `arvalid` rises at T1.
- Data to return latency: the beat with `rlast` at cycle Tn gives `ret_valid` at Tn+1.
- Best case, single word, `arready` and `rvalid` immediate: `rd_rdy` T0, `arvalid` T1, R beat T2, `ret_valid` T3, IDLE (new grant possible) T4.
- Best case, line: `ret_valid` at T10.
- Back-to-back: a request pending during RET is granted in the IDLE cycle that follows, with no extra bubble.

## Test plan
- Icache line request, addr 0x1FC0_0020, type 1, R beats 0x0..0x7 with no wait states:
  - AR carries `arid` 0, `arlen` 7, `arsize` 2, `arburst` 1, `araddr` 0x1FC0_0020.
  - `i_ret_valid` one cycle at T10 with `i_ret_data` = {32'h7,…,32'h0}.
- Dcache uncached word, addr 0xBFAF_8000, type 0, `rdata` 0xDEADBEEF:
  - `arlen` 0, `arid` 1.
  - `d_ret_data[31:0]` = 0xDEADBEEF, upper bits 0.
  - `d_ret_valid` at T3.
- Both `rd_req` high from reset, held:
  - Dcache granted first, icache second, dcache third (alternation).
  - The loser's `rd_rdy` is never 1 in the same cycle as the winner's.
- `arready` delayed 3 cycles, `rvalid` gaps of 2 cycles between beats:
  - AR fields stable throughout the wait.
  - Buffer order correct.
  - `ret_valid` one cycle after `rlast`.
- Line request with `rlast` on beat 4 (early):
  - RET entered; words 4..7 of `ret_data` = 0.
- Reset asserted during R after 3 beats:
  - All outputs return to reset values asynchronously.
  - After release, a new icache request completes normally.

Source files
------------

// File: rtl/cache_rd_arbiter.sv
// rtl/cache_rd_arbiter.sv - round-robin icache/dcache arbiter onto one AXI read channel
//
// Purpose:
//   Grants one of two cache read ports at a time, issues a single AXI AR
//   burst, collects the R beats into a 256-bit line buffer and hands that
//   buffer back to the granted cache with a one-cycle ret_valid pulse.
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   i_rd_req/type/addr, i_rd_rdy     icache request port
//   i_ret_valid, i_ret_data          icache return port
//   d_rd_req/type/addr, d_rd_rdy     dcache request port
//   d_ret_valid, d_ret_data          dcache return port
//   ar*                              AXI read address channel (master side)
//   r*                               AXI read data channel (master side)

module cache_rd_arbiter #(
  parameter logic [3:0] ID_I = 4'd0,
  parameter logic [3:0] ID_D = 4'd1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_rd_req,
  input  logic         i_rd_type,
  input  logic [31:0]  i_rd_addr,
  output logic         i_rd_rdy,
  output logic         i_ret_valid,
  output logic [255:0] i_ret_data,
  input  logic         d_rd_req,
  input  logic         d_rd_type,
  input  logic [31:0]  d_rd_addr,
  output logic         d_rd_rdy,
  output logic         d_ret_valid,
  output logic [255:0] d_ret_data,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready
);

  typedef enum logic [1:0] {ST_IDLE, ST_AR, ST_R, ST_RET} state_t;

  state_t         state_q, state_d;
  logic           last_grant_q, last_grant_d;  // 0 = icache, 1 = dcache
  logic           grant_q, grant_d;            // 0 = icache, 1 = dcache
  logic           type_q, type_d;
  logic [31:0]    addr_q, addr_d;
  logic [255:0]   line_q, line_d;
  logic [2:0]     cnt_q, cnt_d;

  logic           sel_d;
  logic           i_rdy, d_rdy;
  logic           accept;
  logic           unused_r_fields;

  // Responses are never checked: only one burst is ever outstanding, so
  // the ID carries no information, and errors are not reported upstream.
  assign unused_r_fields = ^{rid, rresp};

  // dcache wins when it is alone, or on a tie when icache had the last grant.
  assign sel_d  = d_rd_req && (!i_rd_req || !last_grant_q);
  assign i_rdy  = (state_q == ST_IDLE) && i_rd_req && !sel_d;
  assign d_rdy  = (state_q == ST_IDLE) && sel_d;
  assign accept = i_rdy || d_rdy;

  assign i_rd_rdy    = i_rdy;
  assign d_rd_rdy    = d_rdy;

  assign arvalid     = (state_q == ST_AR);
  assign arid        = grant_q ? ID_D : ID_I;
  assign araddr      = addr_q;
  assign arlen       = type_q ? 8'd7 : 8'd0;
  assign arsize      = 3'b010;
  assign arburst     = 2'b01;
  assign rready      = (state_q == ST_R);

  assign i_ret_valid = (state_q == ST_RET) && !grant_q;
  assign d_ret_valid = (state_q == ST_RET) && grant_q;
  assign i_ret_data  = line_q;
  assign d_ret_data  = line_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    type_d       = type_q;
    addr_d       = addr_q;
    line_d       = line_q;
    cnt_d        = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          grant_d      = sel_d;
          last_grant_d = sel_d;
          type_d       = sel_d ? d_rd_type : i_rd_type;
          addr_d       = sel_d ? d_rd_addr : i_rd_addr;
          line_d       = '0;
          cnt_d        = '0;
          state_d      = ST_AR;
        end
      end
      ST_AR: begin
        if (arready) begin
          state_d = ST_R;
        end
      end
      ST_R: begin
        if (rvalid) begin
          // cnt wraps mod 8, so an over-long burst overwrites from word 0.
          line_d[{cnt_q, 5'd0} +: 32] = rdata;
          cnt_d = cnt_q + 3'd1;
          if (rlast) begin
            state_d = ST_RET;
          end
        end
      end
      ST_RET: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b0;
      grant_q      <= 1'b0;
      type_q       <= 1'b0;
      addr_q       <= '0;
      line_q       <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      type_q       <= type_d;
      addr_q       <= addr_d;
      line_q       <= line_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// tb/tb_cache_rd_arbiter.sv - scoreboard bench for cache_rd_arbiter

module tb_cache_rd_arbiter;

  localparam logic [3:0] ID_I = 4'd0;
  localparam logic [3:0] ID_D = 4'd1;

  logic         clk;
  logic         reset;
  logic         i_rd_req, i_rd_type, i_rd_rdy, i_ret_valid;
  logic [31:0]  i_rd_addr;
  logic [255:0] i_ret_data;
  logic         d_rd_req, d_rd_type, d_rd_rdy, d_ret_valid;
  logic [31:0]  d_rd_addr;
  logic [255:0] d_ret_data;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid, arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast, rvalid, rready;

  cache_rd_arbiter #(.ID_I(ID_I), .ID_D(ID_D)) dut (
    .clk(clk), .reset(reset),
    .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
    .i_ret_valid(i_ret_valid), .i_ret_data(i_ret_data),
    .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
    .d_ret_valid(d_ret_valid), .d_ret_data(d_ret_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Transaction pool: every request the bench issues gets an id here.
  bit          t_side [256];   // 1 = dcache
  bit          t_typ  [256];
  logic [31:0] t_addr [256];
  int          t_nb   [256];
  int          t_ard  [256];
  int          t_gap  [256][12];
  logic [31:0] t_data [256][12];
  int          t_rst  [256];   // reset after this many beats, 0 = never
  int          ntx = 0;

  int           slv_q [$];
  bit           sb_side [$];
  logic [255:0] sb_line [$];
  bit           slv_busy = 1'b0;
  bit           rst_done = 1'b0;
  bit           lg = 1'b0;     // model of last grant, 0 = icache

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Returned line: beat k lands in word k mod 8, everything else reads 0.
  function automatic logic [255:0] model_line(input int id);
    logic [31:0] w [8];
    for (int j = 0; j < 8; j++) w[j] = 32'd0;
    for (int k = 0; k < t_nb[id]; k++) w[k % 8] = t_data[id][k];
    return {w[7], w[6], w[5], w[4], w[3], w[2], w[1], w[0]};
  endfunction

  task automatic mk(input bit side, input bit typ, input logic [31:0] addr, input int nb, output int id);
    id = ntx; ntx++;
    t_side[id] = side; t_typ[id] = typ; t_addr[id] = addr; t_nb[id] = nb;
    t_ard[id] = 0; t_rst[id] = 0;
    for (int k = 0; k < 12; k++) begin
      t_gap[id][k] = 0;
      t_data[id][k] = $urandom;
    end
  endtask

  task automatic gen(input bit side, output int id);
    int nb;
    bit typ;
    typ = 1'($urandom);
    if (!typ) nb = 1;
    else if ($urandom_range(0, 9) < 6) nb = 8;
    else nb = $urandom_range(1, 10);
    mk(side, typ, $urandom, nb, id);
    t_ard[id] = $urandom_range(0, 3);
    for (int k = 0; k < 12; k++) t_gap[id][k] = $urandom_range(0, 2);
  endtask

  task automatic push_exp(input int id);
    slv_q.push_back(id);
    if (t_rst[id] == 0) begin
      sb_side.push_back(t_side[id]);
      sb_line.push_back(model_line(id));
    end
  endtask

  // Present requests and hold them until granted; checks grant order from the
  // round-robin model and that arvalid follows one cycle after acceptance.
  task automatic issue(input bit do_i, input bit do_d, input int id_i, input int id_d);
    bit first_d, nxt, got, pend_i, pend_d;
    int budget;
    first_d = (do_i && do_d) ? !lg : do_d;
    if (first_d) begin
      push_exp(id_d);
      if (do_i) push_exp(id_i);
    end else begin
      push_exp(id_i);
      if (do_d) push_exp(id_d);
    end
    lg = (do_i && do_d) ? !first_d : first_d;
    pend_i = do_i; pend_d = do_d; nxt = first_d; budget = 400;
    if (do_i) begin i_rd_req = 1'b1; i_rd_type = t_typ[id_i]; i_rd_addr = t_addr[id_i]; end
    if (do_d) begin d_rd_req = 1'b1; d_rd_type = t_typ[id_d]; d_rd_addr = t_addr[id_d]; end
    while ((pend_i || pend_d) && budget > 0) begin
      #1;
      chk("rdy_exclusive", 256'(i_rd_rdy & d_rd_rdy), 256'(0));
      if ((i_rd_rdy && pend_i) || (d_rd_rdy && pend_d)) begin
        got = d_rd_rdy && pend_d;
        chk("grant_order", 256'(got), 256'(nxt));
        if (got) pend_d = 1'b0; else pend_i = 1'b0;
        nxt = !nxt;
        @(negedge clk);
        chk("arvalid_t1", 256'(arvalid), 256'(1));
        if (got) d_rd_req = 1'b0; else i_rd_req = 1'b0;
      end else begin
        @(negedge clk);
      end
      budget--;
    end
    chk("grant_timeout", 256'({pend_i, pend_d}), 256'(0));
    i_rd_req = 1'b0; d_rd_req = 1'b0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 500;
    do begin
      @(negedge clk);
      budget--;
    end while ((slv_q.size() != 0 || sb_side.size() != 0 || slv_busy) && budget > 0);
    chk("drain_timeout", 256'({slv_q.size() != 0, sb_side.size() != 0, slv_busy}), 256'(0));
  endtask

  // AXI slave: owns the AR/R inputs and reset.
  initial begin : axi_slave
    int id;
    bit aborted;
    logic [48:0] exp_ar;
    reset = 1'b1; arready = 1'b0; rvalid = 1'b0; rdata = '0; rlast = 1'b0; rid = '0; rresp = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 256'({arvalid, rready, i_ret_valid, d_ret_valid, arid, arlen, araddr}), 256'(0));
    chk("reset_data", i_ret_data | d_ret_data, 256'(0));
    chk("reset_rdy", 256'({i_rd_rdy, d_rd_rdy}), 256'(0));
    reset = 1'b0;
    rst_done = 1'b1;
    forever begin
      @(negedge clk);
      if (!arvalid) begin
        // junk on R while no burst is active; the block must ignore it
        rvalid = 1'($urandom); rdata = $urandom; rlast = 1'($urandom); rid = 4'($urandom);
        continue;
      end
      if (slv_q.size() == 0) begin
        chk("unexpected_ar", 256'(1), 256'(0));
        continue;
      end
      id = slv_q.pop_front();
      slv_busy = 1'b1;
      aborted = 1'b0;
      exp_ar = {t_side[id] ? ID_D : ID_I, t_addr[id], t_typ[id] ? 8'd7 : 8'd0, 3'b010, 2'b01};
      chk("ar_fields", 256'({arid, araddr, arlen, arsize, arburst}), 256'(exp_ar));
      chk("rready_in_ar", 256'(rready), 256'(0));
      for (int w = 0; w < t_ard[id]; w++) begin
        rvalid = 1'($urandom); rdata = $urandom; rlast = 1'($urandom);
        @(negedge clk);
        chk("ar_stable", 256'({arvalid, arid, araddr, arlen, arsize, arburst}), 256'({1'b1, exp_ar}));
      end
      arready = 1'b1; rvalid = 1'b0; rlast = 1'b0;
      @(negedge clk);
      arready = 1'b0;
      for (int k = 0; k < t_nb[id] && !aborted; k++) begin
        for (int g = 0; g < t_gap[id][k]; g++) @(negedge clk);
        rvalid = 1'b1; rdata = t_data[id][k]; rlast = (k == t_nb[id] - 1);
        rresp = 2'($urandom); rid = 4'($urandom);
        chk("rready_in_r", 256'(rready), 256'(1));
        @(negedge clk);
        rvalid = 1'b0; rlast = 1'b0;
        if (t_rst[id] == k + 1) begin
          reset = 1'b1;
          #1;
          chk("midrst_ctrl", 256'({arvalid, rready, i_ret_valid, d_ret_valid, arid, arlen, araddr}), 256'(0));
          chk("midrst_data", i_ret_data | d_ret_data, 256'(0));
          @(negedge clk);
          reset = 1'b0;
          aborted = 1'b1;
        end
      end
      if (!aborted) begin
        chk("ret_after_rlast", 256'({i_ret_valid, d_ret_valid}), 256'(t_side[id] ? 2'b01 : 2'b10));
        @(negedge clk);
        chk("ret_one_cycle", 256'({i_ret_valid, d_ret_valid}), 256'(0));
      end
      slv_busy = 1'b0;
    end
  end

  // Monitor: pops the scoreboard whenever a return pulse is presented.
  initial begin : monitor
    bit s;
    logic [255:0] l;
    forever begin
      @(negedge clk);
      if (!reset && (i_ret_valid || d_ret_valid)) begin
        if (sb_side.size() == 0) begin
          chk("ret_unexpected", 256'(1), 256'(0));
        end else begin
          s = sb_side.pop_front();
          l = sb_line.pop_front();
          chk("ret_side", 256'({i_ret_valid, d_ret_valid}), 256'(s ? 2'b01 : 2'b10));
          chk("ret_data", s ? d_ret_data : i_ret_data, l);
        end
      end
    end
  end

  initial begin : stimulus
    int a, b;
    i_rd_req = 1'b0; i_rd_type = 1'b0; i_rd_addr = '0;
    d_rd_req = 1'b0; d_rd_type = 1'b0; d_rd_addr = '0;
    wait (rst_done);
    @(negedge clk);

    // both caches requesting straight out of reset: D, I, D, I
    mk(0, 1, 32'h0000_1000, 8, a);
    mk(1, 0, 32'h0000_2004, 1, b);
    issue(1, 1, a, b);
    mk(0, 0, 32'h0000_3008, 1, a);
    mk(1, 1, 32'h0000_4000, 8, b);
    issue(1, 1, a, b);
    wait_idle();

    // icache line, no wait states, beats 0..7
    mk(0, 1, 32'h1FC0_0020, 8, a);
    for (int k = 0; k < 8; k++) t_data[a][k] = k;
    issue(1, 0, a, 0);
    wait_idle();

    // dcache uncached word
    mk(1, 0, 32'hBFAF_8000, 1, b);
    t_data[b][0] = 32'hDEAD_BEEF;
    issue(0, 1, 0, b);
    wait_idle();

    // slow slave: arready after 3 cycles, 2-cycle gaps between beats
    mk(0, 1, 32'h0000_8040, 8, a);
    t_ard[a] = 3;
    for (int k = 1; k < 8; k++) t_gap[a][k] = 2;
    issue(1, 0, a, 0);
    wait_idle();

    // early rlast after 4 beats
    mk(1, 1, 32'h0000_9000, 4, b);
    issue(0, 1, 0, b);
    wait_idle();

    // over-long burst without rlast until beat 10
    mk(0, 1, 32'h0000_A000, 10, a);
    issue(1, 0, a, 0);
    wait_idle();

    // reset during R after 3 beats, then a normal icache line
    mk(0, 1, 32'h0000_B000, 8, a);
    t_rst[a] = 3;
    issue(1, 0, a, 0);
    wait_idle();
    lg = 1'b0;
    mk(0, 1, 32'h0000_C020, 8, a);
    issue(1, 0, a, 0);
    wait_idle();

    // randomized mix
    for (int it = 0; it < 40; it++) begin
      int mode;
      mode = $urandom_range(0, 2);
      gen(0, a);
      gen(1, b);
      issue(mode != 1, mode != 0, a, b);
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
